rlbp_serial_tx: RTL

Parametrised multi-channel successor to the single-bit RLBP serial output path. It accepts CHANNELS parallel RLBP codes per word from the pixel/RLBP datapath and buffers them in a FIFO. It then shifts each word out as one serial frame, with a programmable bit period, bit-order select, frame sync and done pulse. It sits between the RLBP core and the io_out pads inside the user macro.

---
 rtl/rlbp_serial_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rlbp_serial_tx.sv
// Multi-channel RLBP serial transmitter: a word FIFO feeding a framed shifter
// with a programmable bit period, bit-order select, frame sync and done pulse.
//
// state   | meaning
// S_IDLE  | no frame in progress; waits for enable and a queued word
// S_LOAD  | pop the head word, latch the bit period, reorder bits for shifting
// S_SHIFT | shift out CHANNELS*CODE_W bits, each held for clk_div+1 cycles
// S_DONE  | one-cycle done pulse; chain straight into the next frame if allowed
module rlbp_serial_tx #(
  parameter int CHANNELS   = 4,
  parameter int CODE_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV_W  = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic                          enable,
  input  logic                          msb_first,
  input  logic [CLK_DIV_W-1:0]          clk_div,
  input  logic                          in_valid,
  input  logic [CHANNELS*CODE_W-1:0]    in_data,
  output logic                          in_ready,
  output logic                          serial_data_out,
  output logic                          bit_strobe,
  output logic                          frame_sync,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int DW  = CHANNELS * CODE_W;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam int BCW = $clog2(DW + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t              state_q;
  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic                ovf_q;
  logic [DW-1:0]       shreg_q;
  logic [DW-1:0]       ordered;
  logic [DW-1:0]       head;
  logic [CLK_DIV_W-1:0] div_q, div_lim_q, div_inc;
  logic [BCW-1:0]      bit_cnt_q;
  logic                ser_q, strobe_q, sync_q, busy_q, done_q;
  logic                push, pop, have_word;

  // in_ready uses the pre-pop level, so a full FIFO drops even when popping
  assign in_ready  = (level_q != LW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == S_LOAD);
  assign have_word = (level_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign div_inc   = div_q + CLK_DIV_W'(1);

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (in_valid && !in_ready) ovf_q <= 1'b1;
      else if (clr_overflow)     ovf_q <= 1'b0;
    end
  end

  // Reorder the head word so the first transmitted bit sits at bit 0
  always_comb begin
    ordered = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      for (int j = 0; j < CODE_W; j++) begin
        ordered[k*CODE_W + j] = msb_first ? head[k*CODE_W + CODE_W - 1 - j]
                                          : head[k*CODE_W + j];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      div_q     <= '0;
      div_lim_q <= '0;
      bit_cnt_q <= '0;
      ser_q     <= 1'b0;
      strobe_q  <= 1'b0;
      sync_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable && have_word) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          shreg_q   <= ordered >> 1;
          ser_q     <= ordered[0];
          div_lim_q <= clk_div;
          div_q     <= '0;
          bit_cnt_q <= '0;
          strobe_q  <= (clk_div == '0);
          sync_q    <= 1'b1;
          state_q   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_q == div_lim_q) begin
            div_q  <= '0;
            sync_q <= 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_q  <= S_DONE;
              ser_q    <= 1'b0;
              strobe_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
              ser_q     <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
              strobe_q  <= (div_lim_q == '0);
            end
          end else begin
            div_q    <= div_inc;
            strobe_q <= (div_inc == div_lim_q);
          end
        end
        S_DONE: begin
          if (enable && have_word) begin
            state_q <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign serial_data_out = ser_q;
  assign bit_strobe      = strobe_q;
  assign frame_sync      = sync_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fifo_level      = level_q;
  assign overflow        = ovf_q;

endmodule
